// File: rtl/mc_muldiv_unit.sv
// mc_muldiv_unit
// Iterative multiply/divide unit with HI/LO registers for the multicycle CPU.
// It decodes the same MIPS R-type func field as the ALU. MULT/MULTU use a
// W-step shift-add and DIV/DIVU use a W-step restoring divide on operand
// magnitudes. The sign is applied in a single FIX cycle. MTHI/MTLO write
// HI/LO directly. MFHI/MFLO are read combinationally through res.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request, sampled only in IDLE
//   func          R-type function code
//   opa, opb      operands (multiplicand/dividend, multiplier/divisor)
//   busy          operation in progress
//   done          one-cycle pulse after HI/LO are updated
//   div_zero      last DIV/DIVU had a zero divisor
//   hi, lo        HI/LO registers
//   res           hi for MFHI, lo for MFLO, otherwise 0
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here
// CALC  | one shift-add / shift-subtract step per cycle, W cycles
// FIX   | sign correction, HI/LO write, done
module mc_muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   func,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] res
);

  localparam int CNT_W = $clog2(W) + 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t         state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   work_hi, work_lo;   // product halves / remainder, quotient
  logic [W-1:0]   operand;            // |multiplicand| or |divisor|
  logic [W-1:0]   opa_raw;            // kept for the divide-by-zero HI result
  logic           is_div, neg_q, neg_r, dz;

  logic           is_muldiv, is_signed, accept_op, accept_mt;
  logic [W-1:0]   opa_abs, opb_abs;
  logic [W:0]     mul_sum, div_shift, div_trial;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   q_fix, r_fix;

  assign is_muldiv = (func == F_MULT) || (func == F_MULTU) ||
                     (func == F_DIV)  || (func == F_DIVU);
  assign is_signed = (func == F_MULT) || (func == F_DIV);
  assign accept_op = (state == S_IDLE) && start && is_muldiv;
  assign accept_mt = (state == S_IDLE) && start &&
                     ((func == F_MTHI) || (func == F_MTLO));

  // Unary minus of MIN gives MIN, which is exactly 2^(W-1) read as unsigned.
  assign opa_abs = (is_signed && opa[W-1]) ? -opa : opa;
  assign opb_abs = (is_signed && opb[W-1]) ? -opb : opb;

  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
  assign div_shift = {work_hi, work_lo[W-1]};
  assign div_trial = div_shift - {1'b0, operand};

  assign prod     = {work_hi, work_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -work_lo : work_lo;
  assign r_fix    = neg_r ? -work_hi : work_hi;

  assign res = (func == F_MFHI) ? hi : (func == F_MFLO) ? lo : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_op) state_nxt = S_CALC;
      S_CALC: if (cnt == CNT_W'(W - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      operand  <= '0;
      opa_raw  <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_op) begin
            is_div  <= func[1];
            busy    <= 1'b1;
            cnt     <= '0;
            work_hi <= '0;
            opa_raw <= opa;
            dz      <= (opb == '0);
            neg_q   <= is_signed && (opa[W-1] ^ opb[W-1]);
            neg_r   <= is_signed && opa[W-1];
            // Multiply walks the multiplier through work_lo; divide shifts
            // the dividend out of work_lo while the quotient shifts in.
            operand <= func[1] ? opb_abs : opa_abs;
            work_lo <= func[1] ? opa_abs : opb_abs;
          end else if (accept_mt) begin
            if (func == F_MTHI) hi <= opa;
            else                lo <= opa;
            done <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_trial[W]) begin
              work_hi <= div_trial[W-1:0];
              work_lo <= {work_lo[W-2:0], 1'b1};
            end else begin
              work_hi <= div_shift[W-1:0];
              work_lo <= {work_lo[W-2:0], 1'b0};
            end
          end else begin
            work_hi <= mul_sum[W:1];
            work_lo <= {mul_sum[0], work_lo[W-1:1]};
          end
        end
        S_FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= is_div && dz;
          if (is_div) begin
            if (dz) begin
              hi <= opa_raw;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
